vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing generator directly upstream of the text screen generator. It divides the system clock into a pixel tick and runs horizontal and vertical counters for 640x480 @ 60 Hz. It produces the `pixel_x`, `pixel_y` and `video_on` that the text generator consumes. It also produces `hsync`/`vsync`, plus copies of `hsync`, `vsync` and `video_on` delayed in clock cycles to match the text generator's two-stage font pipeline at the VGA connector.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; ≥1. With the default, 50 MHz gives a 25 MHz pixel rate.
- `H_DISP`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing, in pixels.
- `V_DISP`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing, in lines.
- `SYNC_DELAY`, 2: delay applied to the `_d` outputs, in clk cycles; 0 means a direct copy.

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `p_tick` out 1: one-clk pulse marking each pixel advance.
- `pixel_x` out 10: horizontal count, 0..H_TOTAL-1.
- `pixel_y` out 10: vertical count, 0..V_TOTAL-1.
- `video_on` out 1: high when pixel_x<H_DISP and pixel_y<V_DISP.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `frame_tick` out 1: one-clk pulse on the last pixel of a frame.
- `hsync_d` out 1: `hsync` delayed by SYNC_DELAY clk.
- `vsync_d` out 1: `vsync` delayed by SYNC_DELAY clk.
- `video_on_d` out 1: `video_on` delayed by SYNC_DELAY clk.

## Operation
Derived constants:
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP, default 800.
- V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP, default 525.

Clock divider:
- `div_cnt` counts 0..CLK_DIV-1 and wraps.
- `p_tick` = (div_cnt == CLK_DIV-1).
- With CLK_DIV=1, `p_tick` is constantly 1 out of reset.

Horizontal counter:
- Advances only on `p_tick`.
- At H_TOTAL-1 it wraps to 0 and the vertical counter advances in the same clk.

Vertical counter:
- At V_TOTAL-1, coinciding with the horizontal wrap, it wraps to 0.

Sync decode:
- `hsync` = 0 for pixel_x in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1]; default range is 656..751.
- `vsync` = 0 for pixel_y in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1]; default range is 490..491.

Decode source and widths:
- `video_on`, `hsync` and `vsync` are combinational decodes of the registered counters, so they are always consistent with `pixel_x`/`pixel_y`.
- `pixel_x` and `pixel_y` are 10-bit unsigned. All comparisons use 10-bit unsigned constants, and no intermediate value exceeds 10 bits.

`frame_tick` = p_tick && pixel_x==H_TOTAL-1 && pixel_y==V_TOTAL-1.

Delay line:
- Three-bit shift register of depth SYNC_DELAY, clocked every clk (not gated by p_tick).
- Input is {hsync, vsync, video_on}.

## Timing
Reset values (asynchronous assertion):
- div_cnt=0, pixel_x=0, pixel_y=0, p_tick=0.
- Decoded from the zero counters: video_on=1, hsync=1, vsync=1, frame_tick=0.
- Delay stages: hsync_d=1, vsync_d=1, video_on_d=0.

After reset release:
- The first `p_tick` occurs on the CLK_DIV-th rising edge after release; CLK_DIV=1 is the exception (above).
- The counters change on the edge after a clk in which p_tick=1.
- `pixel_x`/`pixel_y` hold for exactly CLK_DIV clks per pixel.

Delay outputs:
- `_d` outputs lag their sources by exactly SYNC_DELAY clk edges.
- On release, the delay line shifts in live values; reset values appear on `_d` for the first SYNC_DELAY clks.

Frame period = H_TOTAL·V_TOTAL·CLK_DIV clks, default 840,000.

Reset asserted mid-frame:
- All state returns to reset values immediately, without waiting for a clock edge.
- The next frame restarts at (0,0); no partial-line recovery.

## Structure
- Shared package `vga_timing_pkg`: default timing constants, H_TOTAL/V_TOTAL, and the pixel coordinate width (10). The text generator also uses these for MAX_X=H_DISP/8 and MAX_Y=V_DISP/16.
- One sub-module, `sync_delay_line`, parameterised by width and depth, with asynchronous active-low reset and a per-bit reset value. Instantiated once, at width 3.

## Test plan
- Reset held low, then released → at release pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=1, video_on_d=0. First p_tick is on the 2nd clk; pixel_x=1 from the 3rd clk.
- Run one line (1600 clk) → hsync low exactly for pixel_x 656..751 (192 clk). video_on falls when pixel_x=640. pixel_x wraps 799→0 and pixel_y increments in the same clk.
- Run one frame → vsync low only for pixel_y 490..491. Exactly one frame_tick, coinciding with (799,524). Counters then wrap to (0,0). Period is 840,000 clk.
- Compare hsync_d/vsync_d/video_on_d to their sources → identical waveforms shifted by exactly 2 clk. Repeat with SYNC_DELAY=0 (pure copy) and SYNC_DELAY=5.
- Pulse reset_n low mid-line at pixel (300,200) → all outputs return to reset values asynchronously. Timing restarts cleanly from (0,0).
- CLK_DIV=1 build → p_tick constantly 1 after reset, pixel_x advances every clk, and the frame is 420,000 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and pixel coordinate type,
// shared with the text screen generator.
package vga_timing_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;
  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: W-bit shift register of DEPTH clk stages with per-bit reset value;
// DEPTH=0 is a straight wire.
module sync_delay_line #(
  parameter int W = 3,
  parameter int DEPTH = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_sr
    logic [W-1:0] sr_q [DEPTH];
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    assign q_o = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel tick divider, h/v counters, sync/blank decode and
// delayed sync copies aligned to the text generator's font pipeline.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_DISP = DEF_H_DISP,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_DISP = DEF_V_DISP,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int SYNC_DELAY = 2
) (
  input  logic   clk,
  input  logic   reset_n,
  output logic   p_tick,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   video_on,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_tick,
  output logic   hsync_d,
  output logic   vsync_d,
  output logic   video_on_d
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam coord_t X_MAX = coord_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t Y_MAX = coord_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t X_VIS = coord_t'(H_DISP);
  localparam coord_t Y_VIS = coord_t'(V_DISP);
  localparam coord_t HS_START = coord_t'(H_DISP + H_FP);
  localparam coord_t HS_END = coord_t'(H_DISP + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISP + V_FP);
  localparam coord_t VS_END = coord_t'(V_DISP + V_FP + V_SYNC - 1);
  logic [DIV_W-1:0] div_q, div_d;
  coord_t x_q, x_d, y_q, y_d;
  logic tick, x_end, y_end;
  assign tick = div_q == DIV_MAX;
  assign x_end = x_q == X_MAX;
  assign y_end = y_q == Y_MAX;
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    x_d = tick ? (x_end ? '0 : x_q + 1'b1) : x_q;
    y_d = (tick && x_end) ? (y_end ? '0 : y_q + 1'b1) : y_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      div_q <= div_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  // Gating with reset_n keeps p_tick low in reset even when CLK_DIV=1.
  assign p_tick = tick && reset_n;
  assign pixel_x = x_q;
  assign pixel_y = y_q;
  assign video_on = x_q < X_VIS && y_q < Y_VIS;
  assign hsync = !(x_q >= HS_START && x_q <= HS_END);
  assign vsync = !(y_q >= VS_START && y_q <= VS_END);
  assign frame_tick = p_tick && x_end && y_end;
  sync_delay_line #(.W(3), .DEPTH(SYNC_DELAY), .RST_VAL(3'b110)) u_dly (
    .clk(clk),
    .reset_n(reset_n),
    .d_i({hsync, vsync, video_on}),
    .q_o({hsync_d, vsync_d, video_on_d})
  );
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default, small-timing CLK_DIV=3/SYNC_DELAY=5
// and CLK_DIV=1/SYNC_DELAY=0 builds.
module tb_vga_sync_gen;
  logic clk = 0;
  always #5 clk = ~clk;
  logic ra, rb, rc;
  logic [9:0] a_px, a_py, b_px, b_py, c_px, c_py;
  logic a_pt, a_von, a_hs, a_vs, a_ft, a_hsd, a_vsd, a_vond;
  logic b_pt, b_von, b_hs, b_vs, b_ft, b_hsd, b_vsd, b_vond;
  logic c_pt, c_von, c_hs, c_vs, c_ft, c_hsd, c_vsd, c_vond;
  int total = 0, bad = 0;
  vga_sync_gen dut_a (
    .clk(clk), .reset_n(ra), .p_tick(a_pt), .pixel_x(a_px), .pixel_y(a_py),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .video_on_d(a_vond));
  vga_sync_gen #(.CLK_DIV(3), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(5)) dut_b (
    .clk(clk), .reset_n(rb), .p_tick(b_pt), .pixel_x(b_px), .pixel_y(b_py),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .video_on_d(b_vond));
  vga_sync_gen #(.CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(0)) dut_c (
    .clk(clk), .reset_n(rc), .p_tick(c_pt), .pixel_x(c_px), .pixel_y(c_py),
    .video_on(c_von), .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft),
    .hsync_d(c_hsd), .vsync_d(c_vsd), .video_on_d(c_vond));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    logic [2:0] ha[$], hb[$];
    int ticks = 0, hs_low = 0, hs_min = 1023, hs_max = -1, von_fall = -1;
    int wraps = 0, bad_wrap = 0, bad_hold = 0, run = 0, dly_bad = 0;
    int prev_x = 0, prev_y = 0;
    int nft = 0, first_ft = 0, vs_low = 0, vs_min = 1023, vs_max = -1, found = 0;
    int c_ticks = 0, c_xbad = 0, c_dbad = 0, c_nft = 0, c_first = 0;
    ra = 0; rb = 0; rc = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("a_rst_x", a_px, 0);
    chk("a_rst_y", a_py, 0);
    chk("a_rst_sync", {a_hs, a_vs, a_von}, 3'b111);
    chk("a_rst_dly", {a_hsd, a_vsd, a_vond}, 3'b110);
    chk("a_rst_tick", {a_pt, a_ft}, 0);
    chk("c_rst_tick", c_pt, 0);
    // default build: first two lines
    @(negedge clk); ra = 1; #1;
    for (int k = 1; k <= 3300; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (k == 1) chk("a_c1_tick_x", {a_pt, a_px}, 0);
      if (k == 2) chk("a_c2_tick", a_pt, 1);
      if (k == 3) chk("a_c3_x", a_px, 1);
      ticks += int'(a_pt);
      if (a_py == 0 && !a_hs) begin
        hs_low++;
        if (int'(a_px) < hs_min) hs_min = int'(a_px);
        if (int'(a_px) > hs_max) hs_max = int'(a_px);
      end
      if (a_py == 0 && !a_von && von_fall < 0) von_fall = int'(a_px);
      if (k > 1 && int'(a_px) != prev_x) begin
        if (run != 2) bad_hold++;
        run = 1;
        if (prev_x == 799) begin
          wraps++;
          if (a_px != 0 || int'(a_py) != prev_y + 1) bad_wrap++;
        end
      end else run++;
      ha.push_back({a_hs, a_vs, a_von});
      if ({a_hsd, a_vsd, a_vond} !== ((k <= 2) ? 3'b110 : ha[k-3])) dly_bad++;
      prev_x = int'(a_px); prev_y = int'(a_py);
    end
    chk("a_ticks", ticks, 1650);
    chk("a_hs_low_clks", hs_low, 192);
    chk("a_hs_first_x", hs_min, 656);
    chk("a_hs_last_x", hs_max, 751);
    chk("a_von_fall_x", von_fall, 640);
    chk("a_wraps", wraps, 2);
    chk("a_bad_wrap", bad_wrap, 0);
    chk("a_bad_hold", bad_hold, 0);
    chk("a_dly2_bad", dly_bad, 0);
    chk("a_end_y", a_py, 2);
    // small timing, CLK_DIV=3, SYNC_DELAY=5: frame = 16*10*3 = 480 clk
    dly_bad = 0;
    @(negedge clk); rb = 1; #1;
    for (int k = 1; k <= 1000; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (b_ft) begin
        nft++;
        if (nft == 1) begin
          first_ft = k;
          chk("b_ft_xy", {b_px, b_py}, {10'd15, 10'd9});
        end
      end
      if (k == 481) chk("b_wrap_xy", {b_px, b_py}, 0);
      if (k <= 480 && !b_vs) begin
        vs_low++;
        if (int'(b_py) < vs_min) vs_min = int'(b_py);
        if (int'(b_py) > vs_max) vs_max = int'(b_py);
      end
      hb.push_back({b_hs, b_vs, b_von});
      if ({b_hsd, b_vsd, b_vond} !== ((k <= 5) ? 3'b110 : hb[k-6])) dly_bad++;
    end
    chk("b_first_ft", first_ft, 480);
    chk("b_nft", nft, 2);
    chk("b_vs_low_clks", vs_low, 96);
    chk("b_vs_rows", {vs_min[9:0], vs_max[9:0]}, {10'd7, 10'd8});
    chk("b_dly5_bad", dly_bad, 0);
    // asynchronous reset mid-frame, no clock edge before checking
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk); #1;
      if (b_px == 5 && b_py == 3) found = 1;
    end
    chk("b_reach_5_3", found, 1);
    chk("b_pre_rst_vond", b_vond, 1);
    #2 rb = 0;
    #1;
    chk("b_arst_xy", {b_px, b_py}, 0);
    chk("b_arst_tick", {b_pt, b_ft}, 0);
    chk("b_arst_dly", {b_hsd, b_vsd, b_vond}, 3'b110);
    @(negedge clk); rb = 1; #1;
    first_ft = 0;
    for (int k = 1; k <= 1000 && first_ft == 0; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (b_ft) first_ft = k;
    end
    chk("b_restart_ft", first_ft, 480);
    // CLK_DIV=1, SYNC_DELAY=0: frame = 160 clk
    @(negedge clk); rc = 1; #1;
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      c_ticks += int'(c_pt);
      if (int'(c_px) != (k - 1) % 16) c_xbad++;
      if ({c_hsd, c_vsd, c_vond} !== {c_hs, c_vs, c_von}) c_dbad++;
      if (c_ft) begin
        c_nft++;
        if (c_nft == 1) c_first = k;
      end
    end
    chk("c_ticks", c_ticks, 400);
    chk("c_x_bad", c_xbad, 0);
    chk("c_dly0_bad", c_dbad, 0);
    chk("c_first_ft", c_first, 160);
    chk("c_nft", c_nft, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
